// File: rtl/booth_mult_r4_pipe.sv
// rtl/booth_mult_r4_pipe.sv - iterative radix-4 Booth multiplier, signed/unsigned, valid/ready
module booth_mult_r4_pipe #(
    parameter  int WIDTH    = 16,
    localparam int OUTWIDTH = 2 * WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_signed,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTWIDTH-1:0] Y,
    output logic                busy
);

    localparam int EXT_W = WIDTH + 2;
    localparam int SUM_W = WIDTH + 3;
    localparam int ACC_W = SUM_W + EXT_W;
    localparam int STEPS = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(STEPS + 1);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
        $error("booth_mult_r4_pipe: WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [EXT_W-1:0]   a_ext;
    logic [ACC_W-1:0]   acc;
    logic               lostbit;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic [EXT_W-1:0]   load_a;
    logic [EXT_W-1:0]   load_b;
    logic [SUM_W-1:0]   hi;
    logic [EXT_W-1:0]   lo;
    logic [SUM_W-1:0]   a_x1;
    logic [SUM_W-1:0]   a_x2;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_step;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state == CALC);
    assign accept   = in_valid && in_ready;

    // Extending by two bits makes unsigned operands positive signed values,
    // so a single signed datapath serves both modes.
    assign load_a = is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    assign load_b = is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

    assign hi   = acc[ACC_W-1 -: SUM_W];
    assign lo   = acc[EXT_W-1:0];
    assign a_x1 = {a_ext[EXT_W-1], a_ext};
    assign a_x2 = {a_ext, 1'b0};

    always_comb begin
        sum = hi;
        case ({lo[1:0], lostbit})
            3'b001, 3'b010: sum = hi + a_x1;
            3'b011:         sum = hi + a_x2;
            3'b100:         sum = hi - a_x2;
            3'b101, 3'b110: sum = hi - a_x1;
            default:        sum = hi;
        endcase
    end

    assign acc_step = {{2{sum[SUM_W-1]}}, sum, lo[EXT_W-1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_ext     <= '0;
            acc       <= '0;
            lostbit   <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            case (state)
                CALC: begin
                    acc     <= acc_step;
                    lostbit <= lo[1];
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Y         <= acc_step[OUTWIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new accept overrides the DONE->IDLE transition for back-to-back issue.
            if (accept) begin
                a_ext   <= load_a;
                acc     <= {{SUM_W{1'b0}}, load_b};
                lostbit <= 1'b0;
                count   <= CNT_W'(STEPS);
                state   <= CALC;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_r4_pipe.sv
// tb/tb_booth_mult_r4_pipe.sv - directed and randomised checks of booth_mult_r4_pipe
module tb_booth_mult_r4_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, sgn16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] y16;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] y8;

    int vectors = 0;
    int miscompares = 0;

    booth_mult_r4_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .is_signed(sgn16),
        .A(a16), .B(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .Y(y16), .busy(busy16)
    );

    booth_mult_r4_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .is_signed(sgn8),
        .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Y(y8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the operands interpreted per mode.
    function automatic logic [31:0] ref16(input logic s, input logic [15:0] a, input logic [15:0] b);
        longint pa, pb, p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        longint pa, pb, p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return p[15:0];
    endfunction

    // Presents operands at a negedge; returns at the negedge after the accepting edge.
    task automatic issue16(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_valid16 = 1'b1; sgn16 = s; a16 = a; b16 = b;
        check("in_ready16_at_issue", in_ready16, 1);
        @(negedge clk);
        in_valid16 = 1'b0; sgn16 = ~s; a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    task automatic wait16(input string tag, input logic [31:0] exp);
        int lat;
        lat = 0;
        while (!out_valid16 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_y"}, y16, exp);
    endtask

    task automatic consume16;
        @(negedge clk);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("out_valid16_after_consume", out_valid16, 0);
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        logic s;
        logic [7:0] ra, rb;
        logic [15:0] exp8;

        rst_n = 1'b0;
        in_valid16 = 0; sgn16 = 0; a16 = 0; b16 = 0; out_ready16 = 0;
        in_valid8 = 0;  sgn8 = 0;  a8 = 0;  b8 = 0;  out_ready8 = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready16", in_ready16, 1);
        check("rst_out_valid16", out_valid16, 0);
        check("rst_busy16", busy16, 0);
        check("rst_y16", y16, 0);
        check("rst_in_ready8", in_ready8, 1);
        check("rst_y8", y8, 0);
        rst_n = 1'b1;

        issue16(1, 16'hFFFD, 16'h0005);
        check("busy16_in_calc", busy16, 1);
        check("in_ready16_in_calc", in_ready16, 0);
        wait16("s_m3x5", 32'hFFFFFFF1);
        consume16();

        issue16(0, 16'hFFFF, 16'hFFFF); wait16("u_ffff2", 32'hFFFE0001); consume16();
        issue16(1, 16'hFFFF, 16'hFFFF); wait16("s_ffff2", 32'h00000001); consume16();
        issue16(1, 16'h8000, 16'h8000); wait16("s_8000_2", 32'h40000000); consume16();
        issue16(0, 16'h8000, 16'h8000); wait16("u_8000_2", 32'h40000000); consume16();
        issue16(1, 16'h8000, 16'h7FFF); wait16("s_8000x7fff", 32'hC0008000); consume16();
        issue16(1, 16'h0000, 16'h8000); wait16("s_zero", 32'h0); consume16();

        // Backpressure: result must hold while a new request waits.
        issue16(1, 16'h1234, 16'hFEDC);
        wait16("bp_first", ref16(1, 16'h1234, 16'hFEDC));
        held = y16;
        in_valid16 = 1'b1; sgn16 = 0; a16 = 16'd3; b16 = 16'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_y_stable", y16, held);
            check("bp_out_valid", out_valid16, 1);
            check("bp_in_ready", in_ready16, 0);
        end
        out_ready16 = 1'b1;
        #1 check("b2b_in_ready", in_ready16, 1);
        @(negedge clk);
        out_ready16 = 1'b0; in_valid16 = 1'b0; a16 = 16'hAAAA; b16 = 16'h5555; sgn16 = 1;
        check("b2b_out_valid_drop", out_valid16, 0);
        check("b2b_busy", busy16, 1);
        wait16("b2b_3x7", 32'h00000015);
        consume16();

        // Asynchronous reset four cycles into CALC, with a nonzero Y held.
        issue16(0, 16'h0101, 16'h0202);
        repeat (3) @(negedge clk);
        check("mid_busy_before_reset", busy16, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy16, 0);
        check("mid_rst_in_ready", in_ready16, 1);
        check("mid_rst_out_valid", out_valid16, 0);
        check("mid_rst_y", y16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue16(0, 16'd2, 16'd2);
        wait16("after_rst_2x2", 32'd4);
        consume16();

        // WIDTH=8 randomised against the model, with random consumer delay.
        for (int n = 0; n < 2000; n++) begin
            s  = 1'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n == 0) begin s = 1; ra = 8'h80; rb = 8'h80; end
            if (n == 1) begin s = 0; ra = 8'hFF; rb = 8'hFF; end
            exp8 = ref8(s, ra, rb);
            @(negedge clk);
            in_valid8 = 1'b1; sgn8 = s; a8 = ra; b8 = rb;
            @(negedge clk);
            in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
            lat = 0;
            while (!out_valid8 && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            check("w8_latency", lat, 5);
            check("w8_y", y8, exp8);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
